// File: rtl/reg_dump_reader.sv
// reg_dump_reader
//   Debug-side register file dumper. On a start pulse it walks registers
//   0..NUM_REGS-1 through the register file's debug read port and streams
//   each word out least-significant byte first over a valid/ready byte
//   interface feeding the debug UART transmitter.
//
// Ports
//   clk       in   system clock, rising edge
//   rst       in   asynchronous active-high reset (aborts a running dump)
//   start     in   one-cycle dump request, sampled only when idle
//   busy      out  high while a dump is in progress
//   done      out  one-cycle pulse after the last byte is accepted
//   reg_addr  out  [ADDR_WIDTH] address to the register file debug port
//   reg_data  in   [DATA_WIDTH] combinational read data for reg_addr
//   tx_data   out  [8] byte to transmitter
//   tx_valid  out  tx_data valid
//   tx_ready  in   transmitter accepts when tx_valid && tx_ready at an edge
//
// Build option
//   REG_DUMP_CHECKSUM_EN : append one byte holding the XOR of every data
//                          byte of the dump before done.
module reg_dump_reader #(
  parameter int NUM_REGS   = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] reg_addr,
  input  logic [DATA_WIDTH-1:0] reg_data,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready
);

  localparam int NBYTES = DATA_WIDTH / 8;
  localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDX_W-1:0]      LAST_IDX  = IDX_W'(NBYTES - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_REGS - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SEND
`ifdef REG_DUMP_CHECKSUM_EN
    , CSUM
`endif
  } state_t;

  state_t                  state,    state_nxt;
  logic                    busy_nxt, done_nxt, tx_valid_nxt;
  logic [ADDR_WIDTH-1:0]   reg_addr_nxt;
  logic [7:0]              tx_data_nxt;
  logic [IDX_W-1:0]        byte_idx, byte_idx_nxt, idx_inc;
  logic [DATA_WIDTH-1:0]   data_buf, data_buf_nxt;
  logic                    xfer;
`ifdef REG_DUMP_CHECKSUM_EN
  logic [7:0]              csum, csum_nxt;
`endif

  assign xfer    = tx_valid && tx_ready;
  assign idx_inc = byte_idx + IDX_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      reg_addr <= '0;
      tx_valid <= 1'b0;
      tx_data  <= '0;
      byte_idx <= '0;
      data_buf <= '0;
`ifdef REG_DUMP_CHECKSUM_EN
      csum     <= '0;
`endif
    end else begin
      state    <= state_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
      reg_addr <= reg_addr_nxt;
      tx_valid <= tx_valid_nxt;
      tx_data  <= tx_data_nxt;
      byte_idx <= byte_idx_nxt;
      data_buf <= data_buf_nxt;
`ifdef REG_DUMP_CHECKSUM_EN
      csum     <= csum_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt    = state;
    busy_nxt     = busy;
    done_nxt     = 1'b0;
    reg_addr_nxt = reg_addr;
    tx_valid_nxt = tx_valid;
    tx_data_nxt  = tx_data;
    byte_idx_nxt = byte_idx;
    data_buf_nxt = data_buf;
`ifdef REG_DUMP_CHECKSUM_EN
    csum_nxt     = csum;
`endif

    case (state)
      IDLE: begin
        reg_addr_nxt = '0;
        if (start) begin
          busy_nxt  = 1'b1;
          state_nxt = LOAD;
`ifdef REG_DUMP_CHECKSUM_EN
          csum_nxt  = '0;
`endif
        end
      end

      LOAD: begin
        data_buf_nxt = reg_data;
        byte_idx_nxt = '0;
        tx_data_nxt  = reg_data[7:0];
        tx_valid_nxt = 1'b1;
        state_nxt    = SEND;
      end

      SEND: begin
        if (xfer) begin
`ifdef REG_DUMP_CHECKSUM_EN
          csum_nxt = csum ^ tx_data;
`endif
          if (byte_idx != LAST_IDX) begin
            // Later bytes come from the captured word, not the live port.
            byte_idx_nxt = idx_inc;
            tx_data_nxt  = data_buf[{idx_inc, 3'b000} +: 8];
          end else if (reg_addr != LAST_ADDR) begin
            tx_valid_nxt = 1'b0;
            reg_addr_nxt = reg_addr + ADDR_WIDTH'(1);
            state_nxt    = LOAD;
          end else begin
`ifdef REG_DUMP_CHECKSUM_EN
            // tx_valid stays high: the checksum byte follows directly.
            tx_data_nxt  = csum ^ tx_data;
            state_nxt    = CSUM;
`else
            tx_valid_nxt = 1'b0;
            busy_nxt     = 1'b0;
            done_nxt     = 1'b1;
            state_nxt    = IDLE;
`endif
          end
        end
      end

`ifdef REG_DUMP_CHECKSUM_EN
      CSUM: begin
        if (xfer) begin
          tx_valid_nxt = 1'b0;
          busy_nxt     = 1'b0;
          done_nxt     = 1'b1;
          state_nxt    = IDLE;
        end
      end
`endif

      default: state_nxt = IDLE;
    endcase
  end

endmodule
